// File: rtl/counter_updown.sv
// ============================================================================
//  Module   : counter_updown
//  Purpose  : Range-bounded up/down counter with variable step, load, and
//             wrap/saturate boundary handling. Optional compare pulse is
//             enabled by defining COUNTER_UPDOWN_CMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_updown #(
   parameter int MIN_VALUE   = 0,
   parameter int MAX_VALUE   = 8,
   parameter int WIDTH       = $clog2(MAX_VALUE + 1),
   parameter int STEP_WIDTH  = 4,
   parameter int RESET_VALUE = MIN_VALUE
) (
   input  logic                  clk_i,
   input  logic                  s_rst_i,
   input  logic                  en_i,
   input  logic                  dir_i,
   input  logic [STEP_WIDTH-1:0] step_i,
   input  logic                  sat_i,
   input  logic                  load_i,
   input  logic [WIDTH-1:0]      load_val_i,
`ifdef COUNTER_UPDOWN_CMP_EN
   input  logic [WIDTH-1:0]      cmp_val_i,
   output logic                  cmp_o,
`endif
   output logic [WIDTH-1:0]      val_o,
   output logic                  wrap_o,
   output logic                  sat_o,
   output logic                  at_max_o,
   output logic                  at_min_o
);

   localparam int                c_AW    = WIDTH + STEP_WIDTH + 1;
   localparam logic [c_AW-1:0]   c_MIN   = c_AW'(MIN_VALUE);
   localparam logic [c_AW-1:0]   c_MAX   = c_AW'(MAX_VALUE);
   localparam logic [c_AW-1:0]   c_RANGE = c_AW'(MAX_VALUE - MIN_VALUE + 1);
   localparam logic [c_AW-1:0]   c_ONE   = c_AW'(1);
   localparam logic [WIDTH-1:0]  c_MIN_W = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0]  c_MAX_W = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0]  c_RST_W = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] r_val;
   logic             r_wrap;
   logic             r_sat;

   logic [c_AW-1:0]  w_cur;
   logic [c_AW-1:0]  w_step;
   logic [c_AW-1:0]  w_up_sum;
   logic [c_AW-1:0]  w_dn_diff;
   logic [c_AW-1:0]  w_dn_rel;
   logic             w_up_over;
   logic             w_dn_under;
   logic             w_ld_above;
   logic             w_ld_below;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_next_val;
   logic             w_wrap;
   logic             w_sat;

   assign w_cur      = c_AW'(r_val);
   assign w_step     = c_AW'(step_i);
   assign w_up_sum   = w_cur + w_step;
   assign w_dn_diff  = w_cur - w_step;
   // Distance below MIN; the extra top bit acts as the sign of the result.
   assign w_dn_rel   = w_dn_diff - c_MIN;
   assign w_up_over  = w_up_sum > c_MAX;
   assign w_dn_under = w_dn_rel[c_AW-1];

   // Offsetting both sides by RANGE keeps the lower-bound test well formed when MIN is 0.
   assign w_ld_above = c_AW'(load_val_i) > c_MAX;
   assign w_ld_below = (c_AW'(load_val_i) + c_RANGE) < (c_MIN + c_RANGE);
   assign w_load_val = w_ld_above ? c_MAX_W : (w_ld_below ? c_MIN_W : load_val_i);

   always_comb begin
      w_next_val = r_val;
      w_wrap     = 1'b0;
      w_sat      = 1'b0;
      if (dir_i) begin
         if (!w_up_over) begin
            w_next_val = WIDTH'(w_up_sum);
         end else if (sat_i) begin
            w_next_val = c_MAX_W;
            w_sat      = 1'b1;
         end else begin
            w_next_val = WIDTH'(c_MIN + (w_up_sum - c_MAX - c_ONE) % c_RANGE);
            w_wrap     = 1'b1;
         end
      end else begin
         if (!w_dn_under) begin
            w_next_val = WIDTH'(w_dn_diff);
         end else if (sat_i) begin
            w_next_val = c_MIN_W;
            w_sat      = 1'b1;
         end else begin
            // ~w_dn_rel equals MIN - n - 1 for a negative w_dn_rel.
            w_next_val = WIDTH'(c_MAX - (~w_dn_rel) % c_RANGE);
            w_wrap     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         r_val  <= c_RST_W;
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end else if (load_i) begin
         r_val  <= w_load_val;
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end else if (en_i) begin
         r_val  <= w_next_val;
         r_wrap <= w_wrap;
         r_sat  <= w_sat;
      end else begin
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end
   end

`ifdef COUNTER_UPDOWN_CMP_EN
   logic r_cmp;

   // Only an enabled count that actually moves the value onto cmp_val_i fires.
   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         r_cmp <= 1'b0;
      end else begin
         r_cmp <= !load_i && en_i && (w_next_val == cmp_val_i) && (w_next_val != r_val);
      end
   end

   assign cmp_o = r_cmp;
`endif

   assign val_o    = r_val;
   assign wrap_o   = r_wrap;
   assign sat_o    = r_sat;
   assign at_max_o = (r_val == c_MAX_W);
   assign at_min_o = (r_val == c_MIN_W);

endmodule

`default_nettype wire

// File: tb/tb_counter_updown.sv
// ============================================================================
//  Module   : tb_counter_updown
//  Purpose  : Self-checking bench for counter_updown; two instances cover the
//             [0,8] and [2,9] ranges (compare port under COUNTER_UPDOWN_CMP_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_updown;

   logic       clk = 1'b0;
   logic       s_rst;
   logic       en;
   logic       dir;
   logic [3:0] step;
   logic       sat;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] a_val, b_val;
   logic       a_wrap, a_sat, a_at_max, a_at_min;
   logic       b_wrap, b_sat, b_at_max, b_at_min;
`ifdef COUNTER_UPDOWN_CMP_EN
   logic [3:0] cmp_val;
   logic       a_cmp, b_cmp;
   bit         ma_c, mb_c;
`endif

   int ma, mb;
   bit ma_w, ma_s, mb_w, mb_s;
   int n_err;
   int n_checks;

   always #5 clk = ~clk;

   counter_updown #(.MIN_VALUE(0), .MAX_VALUE(8), .RESET_VALUE(0)) u_a (
      .clk_i(clk), .s_rst_i(s_rst), .en_i(en), .dir_i(dir), .step_i(step),
      .sat_i(sat), .load_i(load), .load_val_i(load_val),
`ifdef COUNTER_UPDOWN_CMP_EN
      .cmp_val_i(cmp_val), .cmp_o(a_cmp),
`endif
      .val_o(a_val), .wrap_o(a_wrap), .sat_o(a_sat),
      .at_max_o(a_at_max), .at_min_o(a_at_min)
   );

   counter_updown #(.MIN_VALUE(2), .MAX_VALUE(9), .RESET_VALUE(5)) u_b (
      .clk_i(clk), .s_rst_i(s_rst), .en_i(en), .dir_i(dir), .step_i(step),
      .sat_i(sat), .load_i(load), .load_val_i(load_val),
`ifdef COUNTER_UPDOWN_CMP_EN
      .cmp_val_i(cmp_val), .cmp_o(b_cmp),
`endif
      .val_o(b_val), .wrap_o(b_wrap), .sat_o(b_sat),
      .at_max_o(b_at_max), .at_min_o(b_at_min)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: saturation by plain arithmetic, wrapping by walking one unit at a time.
   task automatic mstep(input int mn, input int mx, input int rv, input int v,
                        output int nv, output bit w, output bit s);
      int st;
      int lv;
      st = int'(step);
      nv = v;
      w  = 1'b0;
      s  = 1'b0;
      if (s_rst) begin
         nv = rv;
      end else if (load) begin
         lv = int'(load_val);
         nv = (lv > mx) ? mx : ((lv < mn) ? mn : lv);
      end else if (en) begin
         if (sat) begin
            if (dir) begin
               if (v + st > mx) begin nv = mx; s = 1'b1; end
               else nv = v + st;
            end else begin
               if (v - st < mn) begin nv = mn; s = 1'b1; end
               else nv = v - st;
            end
         end else begin
            for (int k = 0; k < st; k++) begin
               if (dir) begin
                  if (nv == mx) begin nv = mn; w = 1'b1; end
                  else nv = nv + 1;
               end else begin
                  if (nv == mn) begin nv = mx; w = 1'b1; end
                  else nv = nv - 1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("a_val",    a_val,    ma);
      chk("a_wrap",   a_wrap,   ma_w);
      chk("a_sat",    a_sat,    ma_s);
      chk("a_at_max", a_at_max, ma == 8);
      chk("a_at_min", a_at_min, ma == 0);
      chk("b_val",    b_val,    mb);
      chk("b_wrap",   b_wrap,   mb_w);
      chk("b_sat",    b_sat,    mb_s);
      chk("b_at_max", b_at_max, mb == 9);
      chk("b_at_min", b_at_min, mb == 2);
      chk("excl_a",   a_wrap & a_sat, 0);
      chk("excl_b",   b_wrap & b_sat, 0);
`ifdef COUNTER_UPDOWN_CMP_EN
      chk("a_cmp",    a_cmp,    ma_c);
      chk("b_cmp",    b_cmp,    mb_c);
`endif
   endtask

   task automatic tick();
      int na, nb;
      bit wa, sa, wb, sb;
      mstep(0, 8, 0, ma, na, wa, sa);
      mstep(2, 9, 5, mb, nb, wb, sb);
`ifdef COUNTER_UPDOWN_CMP_EN
      ma_c = !s_rst && !load && en && (na == int'(cmp_val)) && (na != ma);
      mb_c = !s_rst && !load && en && (nb == int'(cmp_val)) && (nb != mb);
`endif
      ma = na; ma_w = wa; ma_s = sa;
      mb = nb; mb_w = wb; mb_s = sb;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit e, input bit d, input int st, input bit sm,
                        input bit ld, input int lv, input bit r);
      en       = e;
      dir      = d;
      step     = 4'(st);
      sat      = sm;
      load     = ld;
      load_val = 4'(lv);
      s_rst    = r;
      tick();
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      ma = 0; mb = 0;
`ifdef COUNTER_UPDOWN_CMP_EN
      cmp_val = 4'd4;
`endif
      // Reset
      drive(0, 1, 0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 1);
      chk("rst_a_val", a_val, 0);
      chk("rst_b_val", b_val, 5);
      chk("rst_a_wrap", a_wrap, 0);

      // Default count 0..8 then wrap to 0
      for (int i = 1; i <= 8; i++) drive(1, 1, 1, 0, 0, 0, 0);
      chk("t1_a_val8", a_val, 8);
      chk("t1_a_at_max", a_at_max, 1);
      chk("t1_a_wrap_lo", a_wrap, 0);
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("t1_a_val0", a_val, 0);
      chk("t1_a_wrap", a_wrap, 1);

      // Wrap up and down with step on [2,9]
      drive(1, 1, 3, 0, 1, 8, 0);
      chk("t2_b_load8", b_val, 8);
      drive(1, 1, 3, 0, 0, 0, 0);
      chk("t2_b_up_val", b_val, 3);
      chk("t2_b_up_wrap", b_wrap, 1);
      drive(1, 0, 4, 0, 0, 0, 0);
      chk("t2_b_dn_val", b_val, 7);
      chk("t2_b_dn_wrap", b_wrap, 1);

      // Saturate
      drive(0, 1, 5, 1, 1, 7, 0);
      drive(1, 1, 5, 1, 0, 0, 0);
      chk("t3_b_sat_val", b_val, 9);
      chk("t3_b_sat", b_sat, 1);
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 5, 1, 0, 0, 0);
         chk("t3_b_hold_val", b_val, 9);
         chk("t3_b_hold_sat", b_sat, 1);
      end
      drive(1, 0, 15, 1, 0, 0, 0);
      chk("t3_b_dn_val", b_val, 2);
      chk("t3_b_dn_sat", b_sat, 1);

      // Priority and clamping
      drive(1, 1, 3, 0, 1, 5, 0);
      chk("t4_b_load5", b_val, 5);
      chk("t4_b_load_wrap", b_wrap, 0);
      drive(1, 1, 3, 1, 1, 12, 0);
      chk("t4_b_clamp", b_val, 9);
      chk("t4_a_clamp", a_val, 8);
      chk("t4_b_clamp_sat", b_sat, 0);
      drive(1, 1, 3, 0, 1, 7, 1);
      chk("t4_b_rst", b_val, 5);
      chk("t4_a_rst", a_val, 0);

      // Large step and zero step on [0,8]
      drive(1, 1, 15, 0, 0, 0, 0);
      chk("t5_a_big_val", a_val, 6);
      chk("t5_a_big_wrap", a_wrap, 1);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("t5_a_zero_val", a_val, 6);
      chk("t5_a_zero_wrap", a_wrap, 0);
      drive(1, 0, 15, 0, 0, 0, 0);
      chk("t5_a_bigdn_val", a_val, 0);
      drive(0, 1, 3, 0, 0, 0, 0);
      chk("t5_a_dis_val", a_val, 0);

      // Mixed directed sweep checked against the model
      for (int i = 0; i < 80; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 29) == 0);
      end

`ifdef COUNTER_UPDOWN_CMP_EN
      drive(0, 1, 1, 0, 0, 0, 1);
      for (int i = 1; i <= 6; i++) begin
         drive(1, 1, 1, 0, 0, 0, 0);
         chk("t6_a_cmp", a_cmp, i == 4);
      end
      drive(0, 1, 1, 0, 1, 4, 0);
      chk("t6_a_cmp_load", a_cmp, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("t6_a_cmp_hold", a_cmp, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/counter_updown.md
Name: counter_updown

Overview:
- Parametrised successor to the basic free-running modulo counter. Counts within a programmable range [MIN_VALUE, MAX_VALUE].
- Adds the following over the basic counter: up/down direction, variable step, synchronous parallel load, wrap or saturate boundary mode, registered boundary event outputs.
- Used as the general-purpose event, index and timeout counter in datapaths and FSM sequencers.

Parameters:
- MIN_VALUE, 0: lower bound of the count range (inclusive).
- MAX_VALUE, 8: upper bound of the count range (inclusive); must be > MIN_VALUE.
- WIDTH, $clog2(MAX_VALUE + 1): width of val_o and load_val_i.
- STEP_WIDTH, 4: width of step_i.
- RESET_VALUE, MIN_VALUE: value of val_o after reset; must lie within [MIN_VALUE, MAX_VALUE].

Ports:
- clk_i, input, 1: clock. All logic is on the rising edge.
- s_rst_i, input, 1: synchronous reset, active-high.
- en_i, input, 1: count enable.
- dir_i, input, 1: 1 = count up, 0 = count down.
- step_i, input, STEP_WIDTH: increment/decrement magnitude.
- sat_i, input, 1: boundary mode; 1 = saturate, 0 = wrap.
- load_i, input, 1: synchronous load strobe.
- load_val_i, input, WIDTH: value to load.
- val_o, output, WIDTH: current count, registered.
- wrap_o, output, 1: one-cycle pulse; count wrapped past a bound.
- sat_o, output, 1: one-cycle pulse; count clamped at a bound.
- at_max_o, output, 1: val_o == MAX_VALUE (combinational from register).
- at_min_o, output, 1: val_o == MIN_VALUE (combinational from register).

Behaviour:
- Clock and reset: one clock domain, clk_i. Reset is synchronous and active-high on s_rst_i.
- Reset values: val_o = RESET_VALUE; wrap_o = sat_o = 0.
- Priority per edge: s_rst_i > load_i > en_i > hold.
- Load:
  - val <= clamp(load_val_i, MIN_VALUE, MAX_VALUE).
  - wrap_o and sat_o are 0, even when clamping occurs.
  - Latency: 1 cycle.
- Enable with step_i == 0: val holds; no pulses.
- Arithmetic:
  - All sums and differences are computed at WIDTH+STEP_WIDTH+1 bits, so there is no intermediate overflow.
  - RANGE = MAX_VALUE − MIN_VALUE + 1.
- Count up: n = val + step_i.
  - If n ≤ MAX_VALUE: val <= n.
  - Else, wrap mode (sat_i = 0): val <= MIN_VALUE + ((n − MAX_VALUE − 1) mod RANGE); wrap_o <= 1.
  - Else, saturate mode (sat_i = 1): val <= MAX_VALUE; sat_o <= 1.
  - At MAX_VALUE in saturate mode, each further enabled up-step pulses sat_o again. Value is unchanged.
- Count down: n = val − step_i (signed).
  - If n ≥ MIN_VALUE: val <= n.
  - Else, wrap mode: val <= MAX_VALUE − ((MIN_VALUE − n − 1) mod RANGE); wrap_o <= 1.
  - Else, saturate mode: val <= MIN_VALUE; sat_o <= 1.
- Mod operation: the mod is computed combinationally. When step_i < RANGE it reduces to a single subtract/add; the bench covers step_i ≥ RANGE separately.
- Pulse timing: wrap_o and sat_o are registered. They are high in the same cycle val_o first shows the post-boundary value, and low in every other cycle.
- Event exclusivity: wrap_o and sat_o are never high together.
- Mid-operation changes: dir_i, sat_i and step_i may change on any cycle. Each takes effect on the next enabled edge; there is no pipeline state.
- Reset during a pulse cycle: the pulse is cleared on that edge.

Optional Feature:
- Macro: COUNTER_UPDOWN_CMP_EN.
- When defined, add:
  - input cmp_val_i [WIDTH];
  - output cmp_o [1], a registered one-cycle pulse.
- cmp_o pulses in the cycle val_o becomes equal to cmp_val_i after an enabled count. It does not pulse after a load or reset.
- cmp_o does not re-pulse while val_o holds.
- Reset value of cmp_o is 0.
- When the macro is undefined, the ports and logic are absent and the behaviour above is unchanged.

Test Plan:
1. Reset and default count: assert s_rst_i, then en_i=1, dir_i=1, step_i=1, sat_i=0 with MIN=0, MAX=8 → val_o steps 0,1,…,8,0. wrap_o is high exactly in the cycle val_o=0 after 8. at_max_o is high at 8.
2. Wrap up and down with step: MIN=2, MAX=9, load 8, step_i=3, up → val_o=3, wrap_o=1. Then dir_i=0, step_i=4 → val_o=7, wrap_o=1.
3. Saturate: sat_i=1, load 7 (MIN=2, MAX=9), step_i=5, up → val_o=9, sat_o=1. Repeated up-steps keep val_o=9 and pulse sat_o each cycle. Then down with step_i=15 → val_o=2, sat_o=1.
4. Priority and clamping:
   - load_i=1 with en_i=1 and load_val_i=5 → val_o=5 with no count applied.
   - load_val_i=12 with MAX=9 → val_o=9 and no pulses.
   - s_rst_i with load_i → val_o=RESET_VALUE.
5. Large step and zero step (MIN=0, MAX=8, wrap mode):
   - step_i=15, up from 0 → val_o=6, wrap_o=1.
   - step_i=0 with en_i=1 → val_o unchanged and no pulses.
6. With COUNTER_UPDOWN_CMP_EN: cmp_val_i=4, count up from 0 step 1 → cmp_o pulses once at val_o=4. Loading 4 → no cmp_o pulse.
